// File: rtl/bk_adder_pipe_pkg.sv
// Shared constants and elaboration helpers for the pipelined Brent-Kung adder.
package bka_pkg;

    localparam int BKA_MIN_W = 4;
    localparam int BKA_MAX_W = 64;

    function automatic int bka_levels(input int w);
        return $clog2(w);
    endfunction

    function automatic bit is_pow2(input int w);
        return (w > 0) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/bk_adder_pipe_if.sv
// Operand/result handshake bundle for bk_adder_pipe; out_ovf exists only with BKA_OVF_EN.
interface bk_adder_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef BKA_OVF_EN
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
`endif
endinterface

// File: rtl/bk_adder_pipe_dot_cell.sv
// Prefix-tree dot operator: (g,p) = (g_hi | p_hi&g_lo, p_hi&p_lo).
module bka_dot_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);
    assign g = g_hi | (p_hi & g_lo);
    assign p = p_hi & p_lo;
endmodule

// File: rtl/bk_adder_pipe.sv
// 3-stage Brent-Kung adder/subtractor with valid/ready flow control.
// Define BKA_OVF_EN to add the registered signed-overflow output out_ovf.
module bk_adder_pipe
    import bka_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    bk_adder_pipe_if.slave bus
);
    localparam int L = bka_levels(WIDTH);

    if (!is_pow2(WIDTH) || WIDTH < BKA_MIN_W || WIDTH > BKA_MAX_W) begin : g_width_chk
        $error("bk_adder_pipe: WIDTH must be a power of two in 4..64");
    end

    logic             w_adv1, w_adv2, w_adv3;
    logic             r_s1_v, r_s2_v, r_s3_v;
    logic [WIDTH-1:0] r_s1_g, r_s1_p;
    logic             r_s1_c0;
    logic [WIDTH-1:0] r_s2_g, r_s2_p, r_s2_p0;
    logic             r_s2_c0;
    logic [WIDTH-1:0] r_s3_sum;
    logic             r_s3_cout;
    logic [WIDTH-1:0] w_b, w_gup, w_pup, w_gpre, w_ppre;
    logic [WIDTH:0]   w_c;

    assign w_adv3       = !r_s3_v || bus.out_ready;
    assign w_adv2       = !r_s2_v || w_adv3;
    assign w_adv1       = !r_s1_v || w_adv2;
    assign bus.in_ready = w_adv1;

    assign w_b = bus.in_sub ? ~bus.in_b : bus.in_b;

    // Up-sweep: level l combines each node at 2^(l+1)-aligned boundaries with its left span.
    for (genvar l = 0; l < L; l++) begin : g_up
        logic [WIDTH-1:0] w_gi, w_pi, w_go, w_po;
        if (l == 0) begin : g_src
            assign w_gi = r_s1_g;
            assign w_pi = r_s1_p;
        end else begin : g_src
            assign w_gi = g_up[l-1].w_go;
            assign w_pi = g_up[l-1].w_po;
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i + 1) % (2 ** (l + 1))) == 0) begin : g_dot
                bka_dot_cell u_dot (
                    .g_hi(w_gi[i]), .p_hi(w_pi[i]),
                    .g_lo(w_gi[i - 2 ** l]), .p_lo(w_pi[i - 2 ** l]),
                    .g(w_go[i]), .p(w_po[i])
                );
            end else begin : g_pass
                assign w_go[i] = w_gi[i];
                assign w_po[i] = w_pi[i];
            end
        end
    end
    assign w_gup = g_up[L-1].w_go;
    assign w_pup = g_up[L-1].w_po;

    // Down-sweep fills the odd midpoints left unresolved by the up-sweep.
    for (genvar d = 0; d < L - 1; d++) begin : g_dn
        localparam int LV = L - 2 - d;
        logic [WIDTH-1:0] w_gi, w_pi, w_go, w_po;
        if (d == 0) begin : g_src
            assign w_gi = r_s2_g;
            assign w_pi = r_s2_p;
        end else begin : g_src
            assign w_gi = g_dn[d-1].w_go;
            assign w_pi = g_dn[d-1].w_po;
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((((i + 1) % (2 ** (LV + 1))) == 2 ** LV) && (i >= 2 ** (LV + 1))) begin : g_dot
                bka_dot_cell u_dot (
                    .g_hi(w_gi[i]), .p_hi(w_pi[i]),
                    .g_lo(w_gi[i - 2 ** LV]), .p_lo(w_pi[i - 2 ** LV]),
                    .g(w_go[i]), .p(w_po[i])
                );
            end else begin : g_pass
                assign w_go[i] = w_gi[i];
                assign w_po[i] = w_pi[i];
            end
        end
    end
    assign w_gpre = g_dn[L-2].w_go;
    assign w_ppre = g_dn[L-2].w_po;

    // c0 enters as the carry into bit 0, so every prefix sees it through its group propagate.
    assign w_c = {w_gpre | (w_ppre & {WIDTH{r_s2_c0}}), r_s2_c0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_g    <= '0;
            r_s1_p    <= '0;
            r_s1_c0   <= 1'b0;
            r_s2_v    <= 1'b0;
            r_s2_g    <= '0;
            r_s2_p    <= '0;
            r_s2_p0   <= '0;
            r_s2_c0   <= 1'b0;
            r_s3_v    <= 1'b0;
            r_s3_sum  <= '0;
            r_s3_cout <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_s1_v <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_g  <= bus.in_a & w_b;
                    r_s1_p  <= bus.in_a ^ w_b;
                    r_s1_c0 <= bus.in_sub | bus.in_cin;
                end
            end
            if (w_adv2) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_s2_g  <= w_gup;
                    r_s2_p  <= w_pup;
                    r_s2_p0 <= r_s1_p;
                    r_s2_c0 <= r_s1_c0;
                end
            end
            if (w_adv3) begin
                r_s3_v <= r_s2_v;
                if (r_s2_v) begin
                    r_s3_sum  <= r_s2_p0 ^ w_c[WIDTH-1:0];
                    r_s3_cout <= w_c[WIDTH];
                end
            end
        end
    end

    assign bus.out_valid = r_s3_v;
    assign bus.out_sum   = r_s3_sum;
    assign bus.out_cout  = r_s3_cout;

`ifdef BKA_OVF_EN
    logic r_s3_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_ovf <= 1'b0;
        end else if (w_adv3 && r_s2_v) begin
            r_s3_ovf <= w_c[WIDTH] ^ w_c[WIDTH-1];
        end
    end

    assign bus.out_ovf = r_s3_ovf;
`endif

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Self-checking bench for bk_adder_pipe: directed table, random scoreboard, flow-control and reset sequences.
module tb_bk_adder_pipe;

    localparam int W     = 8;
    localparam int NRAND = 3000;
`ifdef BKA_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    bit   mon_en;
    bit   stall_prev;
    logic [W+1:0] prev_vec;
    logic [W+1:0] exp_q[$];

    bk_adder_pipe_if #(.WIDTH(W)) bus ();

    bk_adder_pipe #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        return W'({$urandom, $urandom});
    endfunction

    function automatic logic [W+1:0] out_vec();
`ifdef BKA_OVF_EN
        return {bus.out_ovf, bus.out_cout, bus.out_sum};
`else
        return {1'b0, bus.out_cout, bus.out_sum};
`endif
    endfunction

    // Reference: plain unsigned/signed arithmetic on widened operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W+1:0] sa, sb, sr, u;
        logic         cout, ovf;
        sa = {{2{a[W-1]}}, a};
        sb = {{2{b[W-1]}}, b};
        if (sub) begin
            sr   = sa - sb;
            cout = (a >= b);
        end else begin
            sr   = sa + sb + (W+2)'(cin);
            u    = {2'b00, a} + {2'b00, b} + (W+2)'(cin);
            cout = u[W];
        end
        ovf = (sr[W+1:W-1] != 3'b000) && (sr[W+1:W-1] != 3'b111);
        return {ovf & OVF_EN, cout, sr[W-1:0]};
    endfunction

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (stall_prev) check("stall_hold", {bus.out_valid, out_vec()}, {1'b1, prev_vec});
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_vec   = out_vec();
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("sb_unexpected_output", 1, 0);
                else check("sb_result", out_vec(), exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub));
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Starts and ends #1 after a rising edge; checks latency and result of one isolated beat.
    task automatic single_beat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub, input logic [W+1:0] exp);
        int lat;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = cin;
        bus.in_sub    = sub;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_result"}, out_vec(), exp);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int guard;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic drive_rand_beat();
        bus.in_a   = rnd_w();
        bus.in_b   = rnd_w();
        bus.in_cin = 1'($urandom);
        bus.in_sub = 1'($urandom);
    endtask

    vec_t tbl[8];

    initial begin
        int acc, cyc;
        bit exp_ov;
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;
        stall_prev = 1'b0;
        prev_vec = '0;
        tbl[0] = '{8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1};
        tbl[1] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        tbl[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[4] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[6] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[7] = '{8'h12, 8'h34, 1'b1, 1'b1, 8'hDE, 1'b0, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_outputs", out_vec(), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 8; i++)
            single_beat($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                        {tbl[i].ovf & OVF_EN, tbl[i].cout, tbl[i].sum});

        // Random streaming with random backpressure against the scoreboard.
        mon_en = 1'b1;
        acc = 0;
        cyc = 0;
        while (acc < NRAND && cyc < 20000) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.out_ready = ($urandom_range(3) != 0);
            drive_rand_beat();
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        check("rand_accept_count", acc, NRAND);
        drain();

        // Backpressure: fill with out_ready low, then pass-through while full.
        bus.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            drive_rand_beat();
            @(negedge clk);
            if (bus.in_ready) acc++;
            @(posedge clk); #1;
        end
        check("bp_accepted", acc, 3);
        check("bp_in_ready_full", bus.in_ready, 0);
        check("bp_out_valid_full", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_passthru", bus.in_ready, 1);
        @(negedge clk);
        if (bus.in_ready) acc++;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive_rand_beat();
        #1;
        check("bp_still_full", bus.in_ready, 0);
        check("bp_still_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        cyc = 0;
        while (acc < 8 && cyc < 50) begin
            drive_rand_beat();
            @(negedge clk);
            if (bus.in_ready) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_total_accepted", acc, 8);
        drain();

        // Bubbles: in_valid 1010... with out_ready high; out_valid trails by 3 cycles.
        for (int c = 0; c < 12; c++) begin
            exp_ov = (c >= 3) && (c - 3 < 8) && (((c - 3) % 2) == 0);
            check($sformatf("bubble_out_valid_c%0d", c), bus.out_valid, exp_ov);
            bus.in_valid = (c < 8) && ((c % 2) == 0);
            drive_rand_beat();
            @(posedge clk); #1;
        end
        drain();

        // Reset with three beats in flight.
        mon_en = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1;
            drive_rand_beat();
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("midrst_pre_out_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_outputs", out_vec(), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_no_stale", bus.out_valid, 0);
        single_beat("midrst_new", 8'h5A, 8'h3C, 1'b1, 1'b0, model(8'h5A, 8'h3C, 1'b1, 1'b0));
        single_beat("midrst_sub", 8'h10, 8'h20, 1'b0, 1'b1, model(8'h10, 8'h20, 1'b0, 1'b1));
        exp_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
